// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer that
// schedules ALU operand/result latches and register-file controls per opcode.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle pulse, leaves IDLE
//   imem_req, imem_addr      instruction fetch request and address (PC)
//   imem_valid, imem_rdata   fetch response
//   alu_ctrl                 ALU operation select (EXECUTE only)
//   enable_A/B/C             operand A/B and result C latch enables
//   rf_raddr_a/b             register-file read addresses (DECODE)
//   rf_we, rf_waddr          register-file write strobe/address (WRITEBACK)
//   busy, halted             status: active / stopped on HALT
//   illegal                  sticky illegal-opcode flag
//   instr_count              retired-instruction counter
module instr_sequencer #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_rdata,
  output logic [2:0]      alu_ctrl,
  output logic            enable_A,
  output logic            enable_B,
  output logic            enable_C,
  output logic [2:0]      rf_raddr_a,
  output logic [2:0]      rf_raddr_b,
  output logic            rf_we,
  output logic [2:0]      rf_waddr,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [15:0]     instr_count
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned CNT_W   = 16;

  localparam logic [OP_W-1:0] OP_NOP     = 3'b000;
  localparam logic [OP_W-1:0] OP_ALU_MAX = 3'b100;
  localparam logic [OP_W-1:0] OP_HALT    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt;
  logic [INSTR_W-1:0] ir, ir_nxt;
  logic               illegal_nxt;
  logic [CNT_W-1:0]   instr_count_nxt;

  // Instruction fields
  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rd, rs1, rs2;
  logic             op_is_alu;
  logic             op_is_illegal;

  assign op  = ir[15:13];
  assign rd  = ir[12:10];
  assign rs1 = ir[9:7];
  assign rs2 = ir[6:4];

  assign op_is_alu     = (op != OP_NOP) && (op <= OP_ALU_MAX);
  assign op_is_illegal = (op > OP_ALU_MAX) && (op != OP_HALT);

  // IR[3:0] is reserved in the instruction format and never decoded
  logic unused_ir_low;
  assign unused_ir_low = ^ir[3:0];

  // State and architectural registers; reset wins over any in-flight step
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ir          <= ir_nxt;
      illegal     <= illegal_nxt;
      instr_count <= instr_count_nxt;
    end
  end

  // Next-state and Moore output decode from state and IR
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    ir_nxt          = ir;
    illegal_nxt     = illegal;
    instr_count_nxt = instr_count;

    imem_req   = 1'b0;
    imem_addr  = pc;
    alu_ctrl   = '0;
    enable_A   = 1'b0;
    enable_B   = 1'b0;
    enable_C   = 1'b0;
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    busy       = 1'b0;
    halted     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_nxt    = imem_rdata;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        busy = 1'b1;
        if (op_is_alu) begin
          rf_raddr_a = rs1;
          rf_raddr_b = rs2;
          enable_A   = 1'b1;
          enable_B   = 1'b1;
          state_nxt  = S_EXECUTE;
        end else if (op == OP_HALT) begin
          state_nxt = S_HALT;
        end else begin
          // NOP and illegal opcodes retire here without touching the datapath
          pc_nxt          = pc + PC_W'(1);
          instr_count_nxt = instr_count + CNT_W'(1);
          illegal_nxt     = illegal | op_is_illegal;
          state_nxt       = S_FETCH;
        end
      end

      S_EXECUTE: begin
        busy      = 1'b1;
        alu_ctrl  = op;
        enable_C  = 1'b1;
        state_nxt = S_WRITEBACK;
      end

      S_WRITEBACK: begin
        busy            = 1'b1;
        rf_we           = 1'b1;
        rf_waddr        = rd;
        pc_nxt          = pc + PC_W'(1);
        instr_count_nxt = instr_count + CNT_W'(1);
        state_nxt       = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, imem_valid;
  logic [15:0] imem_rdata;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [2:0]  alu_ctrl, rf_raddr_a, rf_raddr_b, rf_waddr;
  logic        enable_A, enable_B, enable_C, rf_we, busy, halted, illegal;
  logic [15:0] instr_count;

  // Second instance with a 2-bit PC for the wrap check
  logic        s_rst, s_start, s_imem_valid;
  logic [15:0] s_imem_rdata;
  logic        s_imem_req;
  logic [1:0]  s_imem_addr;
  logic [2:0]  s_alu_ctrl, s_rf_raddr_a, s_rf_raddr_b, s_rf_waddr;
  logic        s_enable_A, s_enable_B, s_enable_C, s_rf_we, s_busy, s_halted, s_illegal;
  logic [15:0] s_instr_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural state only
  logic [7:0]  m_pc;
  logic [15:0] m_cnt;
  logic        m_ill;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .alu_ctrl(alu_ctrl), .enable_A(enable_A), .enable_B(enable_B), .enable_C(enable_C),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .busy(busy), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  instr_sequencer #(.PC_W(2)) u_small (
    .clk(clk), .rst(s_rst), .start(s_start),
    .imem_req(s_imem_req), .imem_addr(s_imem_addr),
    .imem_valid(s_imem_valid), .imem_rdata(s_imem_rdata),
    .alu_ctrl(s_alu_ctrl), .enable_A(s_enable_A), .enable_B(s_enable_B), .enable_C(s_enable_C),
    .rf_raddr_a(s_rf_raddr_a), .rf_raddr_b(s_rf_raddr_b),
    .rf_we(s_rf_we), .rf_waddr(s_rf_waddr),
    .busy(s_busy), .halted(s_halted), .illegal(s_illegal), .instr_count(s_instr_count)
  );

  logic [43:0] obs_vec;
  assign obs_vec = {imem_req, imem_addr, alu_ctrl, enable_A, enable_B, enable_C,
                    rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, busy, halted, illegal, instr_count};

  function automatic logic [43:0] ev(
    input logic req, input logic [7:0] addr, input logic [2:0] alu,
    input logic ea, input logic eb, input logic ec,
    input logic [2:0] ra, input logic [2:0] rb,
    input logic we, input logic [2:0] wa,
    input logic bsy, input logic hlt, input logic ill, input logic [15:0] cnt);
    return {req, addr, alu, ea, eb, ec, ra, rb, we, wa, bsy, hlt, ill, cnt};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait to the falling edge, then compare the full output vector
  task automatic cyc(input string tag, input logic [43:0] exp);
    @(negedge clk);
    chk(tag, 64'(obs_vec), 64'(exp));
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_cnt = '0;
    m_ill = 1'b0;
  endtask

  function automatic logic [43:0] idle_vec();
    return ev(0, m_pc, 3'd0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, m_ill, m_cnt);
  endfunction

  // Check IDLE and pulse start so the next cycle is FETCH
  task automatic go();
    start = 1'b0;
    cyc("idle", idle_vec());
    start = 1'b1;
  endtask

  // Run one instruction from FETCH; optionally reset during EXECUTE
  task automatic exec_instr(input logic [15:0] word, input int nwait, input bit rst_exec);
    logic [2:0] op, rd, rs1, rs2;
    bit is_alu;
    op  = word[15:13];
    rd  = word[12:10];
    rs1 = word[9:7];
    rs2 = word[6:4];
    is_alu = (op >= 3'd1) && (op <= 3'd4);

    for (int i = 0; i <= nwait; i++) begin
      cyc("fetch", ev(1, m_pc, 3'd0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 1, 0, m_ill, m_cnt));
      start      = 1'($urandom);
      imem_valid = (i == nwait);
      imem_rdata = (i == nwait) ? word : 16'($urandom);
    end

    if (is_alu)
      cyc("decode_alu", ev(0, m_pc, 3'd0, 1, 1, 0, rs1, rs2, 0, 3'd0, 1, 0, m_ill, m_cnt));
    else
      cyc("decode_other", ev(0, m_pc, 3'd0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 1, 0, m_ill, m_cnt));
    imem_valid = 1'($urandom);
    imem_rdata = 16'($urandom);
    start      = 1'($urandom);

    if (op == 3'd7) return;
    if (!is_alu) begin
      m_pc  = m_pc + 8'd1;
      m_cnt = m_cnt + 16'd1;
      if (op == 3'd5 || op == 3'd6) m_ill = 1'b1;
      return;
    end

    cyc("execute", ev(0, m_pc, op, 0, 0, 1, 3'd0, 3'd0, 0, 3'd0, 1, 0, m_ill, m_cnt));
    imem_valid = 1'b1;
    imem_rdata = ~word;
    start      = 1'($urandom);
    if (rst_exec) begin
      rst = 1'b1;
      model_reset();
      cyc("rst_idle", idle_vec());
      chk("rst_all_zero", 64'(obs_vec), 64'd0);
      rst        = 1'b0;
      start      = 1'b0;
      imem_valid = 1'b0;
      return;
    end

    cyc("writeback", ev(0, m_pc, 3'd0, 0, 0, 0, 3'd0, 3'd0, 1, rd, 1, 0, m_ill, m_cnt));
    imem_valid = 1'($urandom);
    imem_rdata = 16'($urandom);
    m_pc  = m_pc + 8'd1;
    m_cnt = m_cnt + 16'd1;
  endtask

  function automatic logic [15:0] rand_alu();
    logic [2:0] op;
    op = 3'($urandom_range(1, 4));
    return {op, 13'($urandom)};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    s_rst = 1'b1; s_start = 1'b0; s_imem_valid = 1'b0; s_imem_rdata = '0;
    model_reset();

    // Reset state
    cyc("reset", 44'd0);
    cyc("reset_hold", 44'd0);
    rst = 1'b0;

    // ADD rd=1 rs1=2 rs2=4, zero-wait memory; following fetch shows PC=1, count=1
    go();
    exec_instr(16'h2540, 0, 1'b0);

    // Fetch with 3 wait cycles; junk data on non-valid cycles must not be captured
    exec_instr(rand_alu(), 3, 1'b0);

    // Random instruction mix (no HALT) with random wait states
    for (int k = 0; k < 24; k++) begin
      logic [15:0] w;
      w = {3'($urandom_range(0, 6)), 13'($urandom)};
      exec_instr(w, int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset during EXECUTE
    exec_instr(rand_alu(), 0, 1'b1);

    // NOP, illegal 101, HALT
    go();
    exec_instr(16'h0000 | 16'($urandom_range(0, 8191)), 0, 1'b0);
    exec_instr(16'hA000 | 16'($urandom_range(0, 8191)), 1, 1'b0);
    chk("illegal_sticky_model", 64'(m_ill), 64'd1);
    exec_instr(16'hE000, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc("halt", ev(0, 8'd2, 3'd0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1'b1, 16'd2));
      start      = 1'(k % 2 == 0);
      imem_valid = 1'($urandom);
    end
    start = 1'b0;

    // PC wrap with a 2-bit PC: five SUB instructions
    s_rst = 1'b0;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("small_req", 64'(s_imem_req), 64'd1);
      chk("small_addr", 64'(s_imem_addr), 64'(i % 4));
      s_imem_valid = 1'b1;
      s_imem_rdata = {3'b010, 13'($urandom)};
      @(negedge clk);
      s_imem_valid = 1'b0;
      @(negedge clk);
      chk("small_sub_alu", 64'(s_alu_ctrl), 64'd2);
      @(negedge clk);
      chk("small_we", 64'(s_rf_we), 64'd1);
      @(negedge clk);
    end
    chk("small_count", 64'(s_instr_count), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer that drives the ALU datapath and its operand/result latches. It fetches 16-bit instructions from instruction memory, decodes the 3-bit opcode, and steps through DECODE, EXECUTE and WRITEBACK, asserting `alu_ctrl`, `enable_A`, `enable_B`, `enable_C` and the register-file controls in the correct cycle. It sits between instruction memory and the register-file/ALU datapath and replaces ad-hoc per-opcode enables with a phase-correct schedule.

## Interface
- `PC_W`, 8, program counter and `imem_addr` width.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins execution from IDLE.
- `imem_req` out 1: fetch request, held until `imem_valid`.
- `imem_addr` out PC_W: fetch address (current PC).
- `imem_valid` in 1: `imem_rdata` valid this cycle.
- `imem_rdata` in 16: instruction word.
- `alu_ctrl` out 3: ALU operation select.
- `enable_A`, `enable_B` out 1 each: latch operand registers A/B at end of cycle.
- `enable_C` out 1: latch ALU result register C at end of cycle.
- `rf_raddr_a`, `rf_raddr_b` out 3: register-file read addresses.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 3: register-file write address.
- `busy` out 1: high in any state other than IDLE and HALT.
- `halted` out 1: high in HALT.
- `illegal` out 1: sticky illegal-opcode flag.
- `instr_count` out 16: retired-instruction counter.

## Operation
- Instruction format: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored.
- Opcodes: 000 NOP; 001/010/011/100 ALU ops, `alu_ctrl` equals opcode; 101/110 illegal; 111 HALT.
- Internal registers: state, PC (PC_W), IR (16), `illegal`, `instr_count`.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: all controls 0; `start`=1 -> FETCH. PC is not cleared by `start`.
- FETCH: `imem_req`=1, `imem_addr`=PC; on `imem_valid`, IR<=`imem_rdata`, -> DECODE; otherwise stay.
- DECODE, ALU op: `rf_raddr_a`=rs1, `rf_raddr_b`=rs2, `enable_A`=`enable_B`=1 -> EXECUTE.
- DECODE, NOP or illegal: no enables; PC<=PC+1; `instr_count`+1; -> FETCH. An illegal opcode also sets `illegal`=1.
- DECODE, HALT: -> HALT. PC and count unchanged.
- EXECUTE: `alu_ctrl`=opcode, `enable_C`=1 -> WRITEBACK.
- WRITEBACK: `rf_we`=1, `rf_waddr`=rd; PC<=PC+1; `instr_count`+1 -> FETCH.
- HALT: `halted`=1; `start` ignored; only `rst` exits.
- Outputs are decoded combinationally from state and IR (Moore). `alu_ctrl`=000 outside EXECUTE.
- PC wraps from 2^PC_W-1 to 0. `instr_count` wraps from 0xFFFF to 0.

## Timing
- Reset: state=IDLE, PC=0, IR=0, `illegal`=0, `instr_count`=0.
- Reset output values: all outputs 0.
- `rst` has priority over every event, including mid-instruction. The next cycle is IDLE with no `rf_we` and no PC update.
- ALU instruction latency with zero-wait memory (`imem_valid` in the same cycle as `imem_req`) is 4 cycles: FETCH, DECODE, EXECUTE, WRITEBACK.
- NOP or illegal instruction: 2 cycles.
- Each FETCH wait cycle adds 1 cycle.
- `imem_valid` outside FETCH is ignored.
- `start` is ignored in all states except IDLE.
- `rf_we` is never asserted in the same cycle as `enable_A`/`enable_B`.
- Exactly one `rf_we` pulse per retired ALU instruction.

## Test plan
- Reset, then `start`; memory returns 0x2540 (ADD rd=1, rs1=2, rs2=4) with zero wait. Required:
  - cycle 1: `imem_req`=1, `imem_addr`=0;
  - cycle 2: `enable_A`=`enable_B`=1, read addresses 2/4;
  - cycle 3: `alu_ctrl`=001, `enable_C`=1;
  - cycle 4: `rf_we`=1, `rf_waddr`=1;
  - then PC=1 and `instr_count`=1.
- FETCH with `imem_valid` delayed 3 cycles -> `imem_req` held for 4 cycles, `imem_addr` stable, and IR captured only on the valid cycle.
- Program NOP, opcode 101, then HALT (0xE000). Required:
  - `illegal`=1 after the second instruction;
  - no `rf_we` at any point;
  - `halted`=1 with PC=2 and `instr_count`=2;
  - a subsequent `start` is ignored.
- `rst` asserted during EXECUTE -> next cycle IDLE, all outputs 0, no `rf_we` pulse, PC=0.
- PC_W=2 with 5 consecutive SUB instructions -> `imem_addr` sequence 0, 1, 2, 3, 0.
- Extra `imem_valid` pulses during EXECUTE -> IR unchanged and no state change.
